// File: rtl/clk_1_module_pkg.sv
// rtl/clk_1_module_pkg.sv - shared constants and types for the clk_1 packetizer
// Purpose: packet length constants, FSM state encoding, mode/CRC select
//          encodings and the length lookup used by the length check.
// Ports:   none (package).
package clk_1_module_pkg;

  // Message lengths per mode/CRC. The clk2 engine aligns on the same values:
  // 55 = 60 - 5 (CRC-5 room), 52 = 60 - 8 (CRC-8 room).
  localparam int LEN_CHECK = 60;
  localparam int LEN_GEN5  = 55;
  localparam int LEN_GEN8  = 52;

  // Bit counter width; saturates one past the maximum message length.
  localparam int CNT_W = 7;

  localparam logic MODE_CHECK = 1'b1;
  localparam logic MODE_GEN   = 1'b0;
  localparam logic CRC_SEL5   = 1'b1;
  localparam logic CRC_SEL8   = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] expected_len(input logic mode, input logic crc_sel);
    logic [CNT_W-1:0] len;
    if (mode == MODE_CHECK) begin
      len = CNT_W'(LEN_CHECK);
    end else if (crc_sel == CRC_SEL5) begin
      len = CNT_W'(LEN_GEN5);
    end else begin
      len = CNT_W'(LEN_GEN8);
    end
    return len;
  endfunction

endpackage

// File: rtl/clk_1_module_sipo_collect.sv
// rtl/clk_1_module_sipo_collect.sv - serial-in shift register with saturating bit count
// Purpose: assembles an MSB-first serial stream into a right-aligned word and
//          counts the received bits, saturating at pDATA_WIDTH+1 (overflow).
// Ports:   clk_1, rst_n   clock / async active-low reset
//          load_i         first beat: restart with a single bit, count = 1
//          shift_i        further beat: shift data_i in, count up
//          data_i         serial bit
//          shreg_o        assembled word
//          cnt_o          bits received (saturating)
module clk_1_module_sipo_collect
  import clk_1_module_pkg::*;
#(
  parameter int pDATA_WIDTH = 60
) (
  input  logic                   clk_1,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   shift_i,
  input  logic                   data_i,
  output logic [pDATA_WIDTH-1:0] shreg_o,
  output logic [CNT_W-1:0]       cnt_o
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(pDATA_WIDTH + 1);

  logic [pDATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = {{(pDATA_WIDTH-1){1'b0}}, data_i};
      cnt_d   = CNT_W'(1);
    end else if (shift_i && (cnt_q != CNT_SAT)) begin
      // Once saturated the packet is already a length error; later bits are dropped.
      shreg_d = {shreg_q[pDATA_WIDTH-2:0], data_i};
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign shreg_o = shreg_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/clk_1_module.sv
// rtl/clk_1_module.sv - clk_1 input packetizer feeding the clk2 CRC engine
// Purpose: collects a serial packet, checks its length against mode/CRC,
//          issues a one-cycle clk1_flag with stable message/mode/CRC, then
//          holds off new input for pHOLD_CYCLES cycles.
// Ports:   clk_1, rst_n                 clock / async active-low reset
//          in_valid, in_data            serial beats (MSB first)
//          in_mode, in_CRC              selects, sampled on the first beat
//          in_ready                     a new packet may start
//          clk1_flag                    one-cycle message-valid pulse
//          clk1_message/mode/CRC        latched packet, stable between flags
//          len_err                      one-cycle pulse: packet dropped
module clk_1_module
  import clk_1_module_pkg::*;
#(
  parameter int pDATA_WIDTH  = 60,
  parameter int pHOLD_CYCLES = 32
) (
  input  logic                   clk_1,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_data,
  input  logic                   in_mode,
  input  logic                   in_CRC,
  output logic                   in_ready,
  output logic                   clk1_flag,
  output logic [pDATA_WIDTH-1:0] clk1_message,
  output logic                   clk1_mode,
  output logic                   clk1_CRC,
  output logic                   len_err
);

  localparam int HOLD_W = $clog2(pHOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(pHOLD_CYCLES - 1);

  state_e state_q, state_d;

  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   pend_mode_q, pend_mode_d;
  logic                   pend_crc_q, pend_crc_d;
  logic                   drain_q, drain_d;
  logic                   flag_q, flag_d;
  logic                   err_q, err_d;
  logic [pDATA_WIDTH-1:0] msg_q, msg_d;
  logic                   mode_q, mode_d;
  logic                   crc_q, crc_d;

  logic                   load, shift, pkt_end, len_ok, hold_done, start;
  logic [pDATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]       cnt;

  clk_1_module_sipo_collect #(
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_sipo (
    .clk_1  (clk_1),
    .rst_n  (rst_n),
    .load_i (load),
    .shift_i(shift),
    .data_i (in_data),
    .shreg_o(shreg),
    .cnt_o  (cnt)
  );

  // A packet whose beats were still arriving when the hold ended is drained
  // (ignored) until in_valid drops, so its tail never looks like a new packet.
  assign start     = in_valid && !drain_q;
  assign len_ok    = (cnt == expected_len(pend_mode_q, pend_crc_q));
  assign hold_done = (hold_q == HOLD_LAST);

  // State register
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_COLLECT;
      ST_COLLECT: if (!in_valid) state_d = len_ok ? ST_HOLD : ST_IDLE;
      ST_HOLD:    if (hold_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready = (state_q != ST_HOLD);
    load     = (state_q == ST_IDLE) && start;
    shift    = (state_q == ST_COLLECT) && in_valid;
    pkt_end  = (state_q == ST_COLLECT) && !in_valid;
  end

  // Datapath next state
  always_comb begin
    hold_d      = hold_q;
    pend_mode_d = pend_mode_q;
    pend_crc_d  = pend_crc_q;
    drain_d     = drain_q;
    flag_d      = 1'b0;
    err_d       = 1'b0;
    msg_d       = msg_q;
    mode_d      = mode_q;
    crc_d       = crc_q;

    if (load) begin
      pend_mode_d = in_mode;
      pend_crc_d  = in_CRC;
    end

    if (pkt_end) begin
      hold_d = '0;
      if (len_ok) begin
        flag_d = 1'b1;
        msg_d  = shreg;
        mode_d = pend_mode_q;
        crc_d  = pend_crc_q;
      end else begin
        err_d = 1'b1;
      end
    end

    if (state_q == ST_HOLD) begin
      hold_d = hold_q + HOLD_W'(1);
    end

    if ((state_q == ST_HOLD) && hold_done && in_valid) begin
      drain_d = 1'b1;
    end else if (!in_valid) begin
      drain_d = 1'b0;
    end
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      pend_mode_q <= 1'b0;
      pend_crc_q  <= 1'b0;
      drain_q     <= 1'b0;
      flag_q      <= 1'b0;
      err_q       <= 1'b0;
      msg_q       <= '0;
      mode_q      <= 1'b0;
      crc_q       <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      pend_mode_q <= pend_mode_d;
      pend_crc_q  <= pend_crc_d;
      drain_q     <= drain_d;
      flag_q      <= flag_d;
      err_q       <= err_d;
      msg_q       <= msg_d;
      mode_q      <= mode_d;
      crc_q       <= crc_d;
    end
  end

  assign clk1_flag    = flag_q;
  assign len_err      = err_q;
  assign clk1_message = msg_q;
  assign clk1_mode    = mode_q;
  assign clk1_CRC     = crc_q;

endmodule

// File: tb/tb_clk_1_module.sv
// tb/tb_clk_1_module.sv - self-checking bench for clk_1_module
module tb_clk_1_module;

  localparam int W    = 60;
  localparam int HOLD = 32;

  logic         clk_1 = 1'b0;
  logic         rst_n;
  logic         in_valid, in_data, in_mode, in_CRC;
  logic         in_ready, clk1_flag, clk1_mode, clk1_CRC, len_err;
  logic [W-1:0] clk1_message;

  int checks = 0;
  int errors = 0;
  int flag_total = 0;
  int err_total = 0;

  // Reference state: the last accepted packet
  logic [W-1:0] m_msg;
  logic         m_mode, m_crc;

  always #5 clk_1 = ~clk_1;

  clk_1_module #(.pDATA_WIDTH(W), .pHOLD_CYCLES(HOLD)) dut (
    .clk_1       (clk_1),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_mode     (in_mode),
    .in_CRC      (in_CRC),
    .in_ready    (in_ready),
    .clk1_flag   (clk1_flag),
    .clk1_message(clk1_message),
    .clk1_mode   (clk1_mode),
    .clk1_CRC    (clk1_CRC),
    .len_err     (len_err)
  );

  always @(negedge clk_1) begin
    flag_total <= flag_total + int'(clk1_flag);
    err_total  <= err_total + int'(len_err);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int exp_len(input logic m, input logic c);
    if (m) return 60;
    return c ? 55 : 52;
  endfunction

  // Right-aligned value of the last n bits (n <= 60)
  function automatic logic [W-1:0] pack(input int n, input logic [63:0] bits);
    logic [63:0] mask;
    mask = (64'd1 << n) - 64'd1;
    return W'(bits & mask);
  endfunction

  // Drives n beats (bits[n-1] first); returns in cycle T with in_valid low.
  task automatic drive_packet(input logic m, input logic c, input int n, input logic [63:0] bits);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = bits[n-1-i];
      in_mode  = (i == 0) ? m : 1'($urandom);
      in_CRC   = (i == 0) ? c : 1'($urandom);
      @(posedge clk_1); #1;
    end
    in_valid = 1'b0;
    in_data  = 1'b0;
    in_mode  = 1'b0;
    in_CRC   = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_1); #1;
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 100) begin
      step(1);
      k++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL wait_ready: in_ready=%0b after %0d cycles, required 1", in_ready, k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_data = 0; in_mode = 0; in_CRC = 0;
    m_msg = '0; m_mode = 0; m_crc = 0;
    #23;
    checks += 6;
    if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    if (clk1_flag !== 1'b0)  begin errors++; $display("FAIL reset_flag: got %0b want 0", clk1_flag); end
    if (len_err !== 1'b0)    begin errors++; $display("FAIL reset_len_err: got %0b want 0", len_err); end
    if (clk1_message !== '0) begin errors++; $display("FAIL reset_message: got %h want 0", clk1_message); end
    if (clk1_mode !== 1'b0)  begin errors++; $display("FAIL reset_mode: got %0b want 0", clk1_mode); end
    if (clk1_CRC !== 1'b0)   begin errors++; $display("FAIL reset_crc: got %0b want 0", clk1_CRC); end
    @(negedge clk_1); rst_n = 1'b1;
    @(posedge clk_1); #1;
  endtask

  task automatic test_gen5();
    logic [63:0] bits;
    int f0, low;
    bits = 64'h0012_3456_789A_BCDE;
    f0 = flag_total;
    drive_packet(1'b0, 1'b1, 55, bits);
    step(1);
    m_msg = 60'h012_3456_789A_BCDE; m_mode = 1'b0; m_crc = 1'b1;
    checks += 5;
    if (clk1_flag !== 1'b1)     begin errors++; $display("FAIL gen5_flag: got %0b want 1", clk1_flag); end
    if (clk1_message !== m_msg) begin errors++; $display("FAIL gen5_message: got %h want %h", clk1_message, m_msg); end
    if (clk1_CRC !== 1'b1)      begin errors++; $display("FAIL gen5_crc: got %0b want 1", clk1_CRC); end
    if (clk1_mode !== 1'b0)     begin errors++; $display("FAIL gen5_mode: got %0b want 0", clk1_mode); end
    if (in_ready !== 1'b0)      begin errors++; $display("FAIL gen5_ready_low: got %0b want 0", in_ready); end
    low = 1;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (in_ready) break;
      low++;
    end
    checks += 2;
    if (low != HOLD) begin errors++; $display("FAIL gen5_hold_len: got %0d want %0d", low, HOLD); end
    if (flag_total - f0 != 1) begin errors++; $display("FAIL gen5_flag_count: got %0d want 1", flag_total - f0); end
  endtask

  task automatic test_check8();
    int f0;
    f0 = flag_total;
    drive_packet(1'b1, 1'b0, 60, {64{1'b1}});
    step(1);
    m_msg = 60'hFFF_FFFF_FFFF_FFFF; m_mode = 1'b1; m_crc = 1'b0;
    checks += 4;
    if (clk1_flag !== 1'b1)     begin errors++; $display("FAIL chk8_flag: got %0b want 1", clk1_flag); end
    if (clk1_message !== m_msg) begin errors++; $display("FAIL chk8_message: got %h want %h", clk1_message, m_msg); end
    if (clk1_mode !== 1'b1)     begin errors++; $display("FAIL chk8_mode: got %0b want 1", clk1_mode); end
    if (clk1_CRC !== 1'b0)      begin errors++; $display("FAIL chk8_crc: got %0b want 0", clk1_CRC); end
    step(1);
    checks++;
    if (clk1_flag !== 1'b0) begin errors++; $display("FAIL chk8_single_pulse: got %0b want 0", clk1_flag); end
    wait_ready();
    checks++;
    if (flag_total - f0 != 1) begin errors++; $display("FAIL chk8_flag_count: got %0d want 1", flag_total - f0); end
  endtask

  task automatic test_len_err();
    int f0;
    f0 = flag_total;
    drive_packet(1'b0, 1'b0, 51, {$urandom, $urandom});
    step(1);
    checks += 4;
    if (len_err !== 1'b1)       begin errors++; $display("FAIL lenerr_pulse: got %0b want 1", len_err); end
    if (clk1_message !== m_msg) begin errors++; $display("FAIL lenerr_message_kept: got %h want %h", clk1_message, m_msg); end
    if (clk1_mode !== m_mode)   begin errors++; $display("FAIL lenerr_mode_kept: got %0b want %0b", clk1_mode, m_mode); end
    if (in_ready !== 1'b1)      begin errors++; $display("FAIL lenerr_ready: got %0b want 1", in_ready); end
    step(3);
    checks++;
    if (flag_total != f0) begin errors++; $display("FAIL lenerr_no_flag: got %0d flags want 0", flag_total - f0); end
  endtask

  task automatic test_overflow();
    int f0, e0;
    f0 = flag_total; e0 = err_total;
    drive_packet(1'b1, 1'b0, 64, {$urandom, $urandom});
    step(1);
    checks++;
    if (len_err !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %0b want 1", len_err); end
    step(4);
    checks += 2;
    if (err_total - e0 != 1) begin errors++; $display("FAIL ovf_err_count: got %0d want 1", err_total - e0); end
    if (flag_total != f0)    begin errors++; $display("FAIL ovf_no_flag: got %0d want 0", flag_total - f0); end
  endtask

  task automatic test_holdoff();
    logic [63:0] bits;
    int f0, e0;
    bits = {$urandom, $urandom};
    f0 = flag_total; e0 = err_total;
    drive_packet(1'b0, 1'b0, 52, bits);
    step(1);
    m_msg = pack(52, bits); m_mode = 1'b0; m_crc = 1'b0;
    checks++;
    if (clk1_flag !== 1'b1) begin errors++; $display("FAIL holdoff_first_flag: got %0b want 1", clk1_flag); end
    step(5);
    // Starts inside the hold and keeps going past its end: must be dropped silently.
    drive_packet(1'b0, 1'b1, 55, {$urandom, $urandom});
    step(5);
    checks += 3;
    if (flag_total - f0 != 1)   begin errors++; $display("FAIL holdoff_flags: got %0d want 1", flag_total - f0); end
    if (err_total != e0)        begin errors++; $display("FAIL holdoff_errs: got %0d want 0", err_total - e0); end
    if (clk1_message !== m_msg) begin errors++; $display("FAIL holdoff_message: got %h want %h", clk1_message, m_msg); end
  endtask

  task automatic test_hold_boundary();
    logic [63:0] bits;
    bits = {$urandom, $urandom};
    drive_packet(1'b0, 1'b1, 55, bits);
    step(1);
    checks++;
    if (clk1_flag !== 1'b1) begin errors++; $display("FAIL bound_flag1: got %0b want 1", clk1_flag); end
    step(HOLD - 1);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bound_ready_last_hold: got %0b want 0", in_ready); end
    step(1);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bound_ready_reopen: got %0b want 1", in_ready); end
    drive_packet(1'b0, 1'b1, 55, bits);
    step(1);
    m_msg = pack(55, bits); m_mode = 1'b0; m_crc = 1'b1;
    checks += 2;
    if (clk1_flag !== 1'b1)     begin errors++; $display("FAIL bound_flag2: got %0b want 1", clk1_flag); end
    if (clk1_message !== m_msg) begin errors++; $display("FAIL bound_message: got %h want %h", clk1_message, m_msg); end
    wait_ready();
  endtask

  task automatic test_reset_mid();
    logic [63:0] bits;
    int f0, e0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 1'($urandom); in_mode = 1'b1; in_CRC = 1'b1;
      @(posedge clk_1); #1;
    end
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    m_msg = '0; m_mode = 1'b0; m_crc = 1'b0;
    checks += 4;
    if (clk1_message !== '0) begin errors++; $display("FAIL rstmid_message: got %h want 0", clk1_message); end
    if (clk1_CRC !== 1'b0)   begin errors++; $display("FAIL rstmid_crc: got %0b want 0", clk1_CRC); end
    if (in_ready !== 1'b1)   begin errors++; $display("FAIL rstmid_ready: got %0b want 1", in_ready); end
    if (len_err !== 1'b0)    begin errors++; $display("FAIL rstmid_len_err: got %0b want 0", len_err); end
    @(negedge clk_1); rst_n = 1'b1;
    @(posedge clk_1); #1;
    f0 = flag_total; e0 = err_total;
    bits = {$urandom, $urandom};
    drive_packet(1'b0, 1'b0, 52, bits);
    step(1);
    m_msg = pack(52, bits);
    checks += 4;
    if (clk1_flag !== 1'b1)     begin errors++; $display("FAIL rstmid_flag: got %0b want 1", clk1_flag); end
    if (clk1_message !== m_msg) begin errors++; $display("FAIL rstmid_msg2: got %h want %h", clk1_message, m_msg); end
    if (clk1_CRC !== 1'b0)      begin errors++; $display("FAIL rstmid_crc2: got %0b want 0", clk1_CRC); end
    if (err_total != e0 || flag_total != f0) begin
      errors++; $display("FAIL rstmid_no_stray_pulse: got flags %0d errs %0d want 0 0", flag_total - f0, err_total - e0);
    end
    wait_ready();
  endtask

  task automatic test_random();
    logic        m, c;
    logic [63:0] bits;
    int          el, n, kind;
    for (int it = 0; it < 12; it++) begin
      m    = 1'($urandom);
      c    = 1'($urandom);
      el   = exp_len(m, c);
      kind = int'($urandom_range(0, 3));
      if (kind <= 1)      n = el;
      else if (kind == 2) n = int'($urandom_range(1, 64));
      else                n = el + (($urandom & 1) != 0 ? int'($urandom_range(1, 3)) : -int'($urandom_range(1, 3)));
      bits = {$urandom, $urandom};
      drive_packet(m, c, n, bits);
      step(1);
      checks += 3;
      if (n == el) begin
        m_msg = pack(n, bits); m_mode = m; m_crc = c;
        if (clk1_flag !== 1'b1 || len_err !== 1'b0) begin
          errors++; $display("FAIL rand_accept it=%0d n=%0d: flag=%0b err=%0b want 1 0", it, n, clk1_flag, len_err);
        end
      end else begin
        if (clk1_flag !== 1'b0 || len_err !== 1'b1) begin
          errors++; $display("FAIL rand_reject it=%0d n=%0d: flag=%0b err=%0b want 0 1", it, n, clk1_flag, len_err);
        end
      end
      if (clk1_message !== m_msg) begin
        errors++; $display("FAIL rand_message it=%0d: got %h want %h", it, clk1_message, m_msg);
      end
      if (clk1_mode !== m_mode || clk1_CRC !== m_crc) begin
        errors++; $display("FAIL rand_sel it=%0d: got mode %0b crc %0b want %0b %0b", it, clk1_mode, clk1_CRC, m_mode, m_crc);
      end
      if (n == el) wait_ready();
    end
  endtask

  initial begin
    test_reset();
    test_gen5();
    test_check8();
    test_len_err();
    test_overflow();
    test_holdoff();
    test_hold_boundary();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
